// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Holds the fetch FSM encoding and the reset-time instruction/PC values.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC select and +4 adder; updates only on load.
// Latency: pc moves one edge after load; pc_plus4 is combinational from pc.
module pc_reg #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sel,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    assign pc_plus4 = pc + 32'd4;

    // Redirect targets are forced word-aligned: bits 1:0 are dropped.
    always_comb begin
        pc_next = sel ? {target[31:2], 2'b00} : pc_plus4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: IDLE -> FETCH (request until ack) -> HOLD (present until accepted).
// Latency: inst valid the edge after ack; stall holds the instruction in HOLD indefinitely.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSel,
    input  logic [31:0] alu_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        misalign,
    output logic [31:0] inst_count
);

    import riscv_pkg::*;

    fetch_state_t state, state_next;
    logic         accept;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .sel      (PCSel),
        .target   (alu_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: if (imem_ack) state_next = HOLD;
            HOLD: begin
                if (!stall) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // imem_req is registered from the next state so it is asserted throughout FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req   <= 1'b0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            inst_count <= 32'd0;
        end else begin
            imem_req <= (state_next == FETCH);
            if (state == FETCH && imem_ack) begin
                inst       <= imem_rdata;
                inst_valid <= 1'b1;
            end
            if (accept) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
                inst_count <= inst_count + 32'd1;
                if (PCSel && alu_target[1]) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed test of inst_fetch: reset, zero-wait and delayed fetch, stall, redirect, PC wrap, reset mid-fetch.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSel;
    logic [31:0] alu_target;
    logic        stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        imem_req, inst_valid, misalign;
    logic [31:0] imem_addr, inst, pc, pc_plus4, inst_count;

    logic        w_imem_req, w_inst_valid, w_misalign;
    logic [31:0] w_imem_addr, w_inst, w_pc, w_pc_plus4, w_inst_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .PCSel(PCSel), .alu_target(alu_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
        .misalign(misalign), .inst_count(inst_count)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .PCSel(PCSel), .alu_target(alu_target), .stall(stall),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(w_inst), .pc(w_pc), .pc_plus4(w_pc_plus4), .inst_valid(w_inst_valid),
        .misalign(w_misalign), .inst_count(w_inst_count)
    );

    task automatic test_reset();
        rst = 1'b1; PCSel = 1'b0; alu_target = 32'd0; stall = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        @(negedge clk); @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if (inst !== NOP) begin bad++; $display("FAIL rst_inst got=%h want=%h", inst, NOP); end
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b want=0", misalign); end
        total++; if (inst_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%h want=0", inst_count); end
        total++; if (w_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_wpc got=%h want=fffffffc", w_pc); end
        total++; if (w_pc_plus4 !== 32'd0) begin bad++; $display("FAIL wrap_plus4 got=%h want=0", w_pc_plus4); end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL zw_req got=%b want=1", imem_req); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL zw_addr got=%h want=0", imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL zw_valid0 got=%b want=0", inst_valid); end
        imem_ack = 1'b1; imem_rdata = 32'h0020_8233;
        @(negedge clk);
        total++; if (inst !== 32'h0020_8233) begin bad++; $display("FAIL zw_inst got=%h want=00208233", inst); end
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL zw_valid got=%b want=1", inst_valid); end
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL zw_pc got=%h want=0", pc); end
        total++; if (pc_plus4 !== 32'd4) begin bad++; $display("FAIL zw_plus4 got=%h want=4", pc_plus4); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL zw_req_hold got=%b want=0", imem_req); end
    endtask

    task automatic test_stall();
        // Keep ack high with other data while holding: it must be ignored in HOLD.
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (inst !== 32'h0020_8233) begin bad++; $display("FAIL st_inst[%0d] got=%h want=00208233", i, inst); end
            total++; if (pc !== 32'd0 || inst_valid !== 1'b1) begin bad++; $display("FAIL st_pcv[%0d] got=%h/%b want=0/1", i, pc, inst_valid); end
            total++; if (inst_count !== 32'd0) begin bad++; $display("FAIL st_count[%0d] got=%h want=0", i, inst_count); end
        end
        imem_ack = 1'b0; stall = 1'b0; PCSel = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin bad++; $display("FAIL st_next got=%b/%h want=1/4", imem_req, imem_addr); end
        total++; if (inst_valid !== 1'b0 || inst !== NOP) begin bad++; $display("FAIL st_clear got=%b/%h want=0/%h", inst_valid, inst, NOP); end
        total++; if (inst_count !== 32'd1) begin bad++; $display("FAIL st_count got=%h want=1", inst_count); end
        total++; if (w_imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_addr got=%h want=0", w_imem_addr); end
    endtask

    task automatic test_ack_delay();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin bad++; $display("FAIL dly_req[%0d] got=%b/%h want=1/4", i, imem_req, imem_addr); end
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL dly_valid[%0d] got=%b want=0", i, inst_valid); end
        end
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        @(negedge clk);
        imem_ack = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst !== 32'h1111_2222) begin bad++; $display("FAIL dly_inst got=%b/%h want=1/11112222", inst_valid, inst); end
        total++; if (pc !== 32'd4) begin bad++; $display("FAIL dly_pc got=%h want=4", pc); end
    endtask

    task automatic test_redirect();
        stall = 1'b0; PCSel = 1'b1; alu_target = 32'h0000_0043;
        @(negedge clk);
        PCSel = 1'b0; alu_target = 32'd0; stall = 1'b1;
        total++; if (imem_addr !== 32'h0000_0040) begin bad++; $display("FAIL rd_addr got=%h want=40", imem_addr); end
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL rd_misalign got=%b want=1", misalign); end
        total++; if (inst_count !== 32'd2) begin bad++; $display("FAIL rd_count got=%h want=2", inst_count); end
        imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
        @(negedge clk);
        imem_ack = 1'b0; stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        total++; if (imem_addr !== 32'h0000_0044) begin bad++; $display("FAIL rd_seq_addr got=%h want=44", imem_addr); end
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL rd_sticky got=%b want=1", misalign); end
    endtask

    task automatic test_reset_in_fetch();
        // Currently in FETCH at 0x44 with no ack; reset mid-cycle must act without a clock edge.
        #2 rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rf_req got=%b want=0", imem_req); end
        total++; if (pc !== 32'd0 || inst !== NOP) begin bad++; $display("FAIL rf_pcinst got=%h/%h want=0/%h", pc, inst, NOP); end
        total++; if (misalign !== 1'b0 || inst_count !== 32'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rf_flags got=%b/%h/%b want=0/0/0", misalign, inst_count, inst_valid); end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h5555_6666;
        rst = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL rf_restart got=%b/%h want=1/0", imem_req, imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rf_late_ack got=%b want=0", inst_valid); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_ack_delay();
        test_redirect();
        test_reset_in_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
